// File: rtl/dpd_stream_to_bin.sv
// dpd_stream_to_bin: DPD declet stream to binary, MSD first.
// Option: define DPD_NONCANON_CHECK_EN to flag redundant declets.
module dpd_stream_to_bin #(
  parameter int MAX_DECLETS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [9:0]                 in_declet,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [10*MAX_DECLETS-1:0]  out_bin,
  output logic                       out_ovf,
  output logic                       out_ncan
);

  localparam int W  = 10 * MAX_DECLETS;
  localparam int CW = $clog2(MAX_DECLETS + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    d2, d1, d0;
  logic [9:0]    val;
  logic          accept, hshk, full;

  assign accept = in_valid & in_ready;
  assign hshk   = out_valid & out_ready;
  assign full   = (cnt_q >= CW'(MAX_DECLETS));

  // Unpack one declet into three BCD digits.
  always_comb begin
    d2 = {1'b0, in_declet[9:7]};
    d1 = {1'b0, in_declet[6:4]};
    d0 = {1'b0, in_declet[2:0]};
    if (in_declet[3]) begin
      unique case (in_declet[2:1])
        2'b00: d0 = {3'b100, in_declet[0]};
        2'b01: begin
          d1 = {3'b100, in_declet[4]};
          d0 = {1'b0, in_declet[6:5], in_declet[0]};
        end
        2'b10: begin
          d2 = {3'b100, in_declet[7]};
          d0 = {1'b0, in_declet[9:8], in_declet[0]};
        end
        default: begin
          unique case (in_declet[6:5])
            2'b00: begin
              d2 = {3'b100, in_declet[7]};
              d1 = {3'b100, in_declet[4]};
              d0 = {1'b0, in_declet[9:8], in_declet[0]};
            end
            2'b01: begin
              d2 = {3'b100, in_declet[7]};
              d1 = {1'b0, in_declet[9:8], in_declet[4]};
              d0 = {3'b100, in_declet[0]};
            end
            2'b10: begin
              d1 = {3'b100, in_declet[4]};
              d0 = {3'b100, in_declet[0]};
            end
            default: begin
              d2 = {3'b100, in_declet[7]};
              d1 = {3'b100, in_declet[4]};
              d0 = {3'b100, in_declet[0]};
            end
          endcase
        end
      endcase
    end
  end

  assign val = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);

  // Accumulator, declet count and overflow next-state.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (hshk) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      if (cnt_q != CW'(MAX_DECLETS + 1))
        cnt_d = cnt_q + CW'(1);
      if (full)
        ovf_d = 1'b1;
      else
        acc_d = acc_q * W'(1000) + W'(val);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef DPD_NONCANON_CHECK_EN
  logic ncan_q, ncan_d, redundant;

  assign redundant = (in_declet[3:1] == 3'b111) &
                     (in_declet[6:5] == 2'b11) &
                     (in_declet[9:8] != 2'b00);

  // Sticky flag for redundant declets.
  always_comb begin
    ncan_d = ncan_q;
    if (hshk)
      ncan_d = 1'b0;
    else if (accept && redundant)
      ncan_d = 1'b1;
  end

  // Non-canonical flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncan_q <= 1'b0;
    else        ncan_q <= ncan_d;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = in_last ? DONE : ACCUM;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; result fields are zero outside DONE.
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    out_bin   = '0;
    out_ovf   = 1'b0;
    out_ncan  = 1'b0;
    if (state_q == DONE) begin
      out_bin = ovf_q ? '1 : acc_q;
      out_ovf = ovf_q;
`ifdef DPD_NONCANON_CHECK_EN
      out_ncan = ncan_q;
`endif
    end
  end

endmodule

// File: tb/tb_dpd_stream_to_bin.sv
// tb_dpd_stream_to_bin: directed and swept stimulus
// against a table-driven decimal model of the stream.
module tb_dpd_stream_to_bin;

  localparam int MAXD = 3;
  localparam int W    = 10 * MAXD;
`ifdef DPD_NONCANON_CHECK_EN
  localparam bit NC = 1'b1;
`else
  localparam bit NC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   in_declet = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_bin;
  logic         out_ovf;
  logic         out_ncan;

  int errors = 0;
  int checks = 0;

  int dec_tab [1024];
  bit canon   [1024];

  bit     m_done, m_ovf, m_ncan;
  int     m_n;
  longint m_acc;

  always #5 clk = ~clk;

  dpd_stream_to_bin #(.MAX_DECLETS(MAXD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_declet (in_declet),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_ovf   (out_ovf),
    .out_ncan  (out_ncan)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // canonical IEEE 754-2008 encoder of a value 0..999
  function automatic logic [9:0] enc(int v);
    logic [3:0] a, b, c;
    logic [9:0] r;
    a = 4'(v / 100);
    b = 4'((v / 10) % 10);
    c = 4'(v % 10);
    case ({a[3], b[3], c[3]})
      3'b000: r = {a[2:0], b[2:0], 1'b0, c[2:0]};
      3'b001: r = {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
      3'b010: r = {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
      3'b011: r = {a[2:0], 2'b10, b[0], 1'b1, 2'b11, c[0]};
      3'b100: r = {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
      3'b101: r = {b[2:1], a[0], 2'b01, b[0], 1'b1, 2'b11, c[0]};
      3'b110: r = {c[2:1], a[0], 2'b00, b[0], 1'b1, 2'b11, c[0]};
      default: r = {2'b00, a[0], 2'b11, b[0], 1'b1, 2'b11, c[0]};
    endcase
    return r;
  endfunction

  // reference model: decimal value of the received number
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done = 0; m_ovf = 0; m_ncan = 0; m_n = 0; m_acc = 0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 0; m_ovf = 0; m_ncan = 0; m_n = 0; m_acc = 0;
      end
    end else if (in_valid) begin
      m_n++;
      if (m_n > MAXD) m_ovf = 1;
      else m_acc = (m_acc * 1000 + dec_tab[in_declet]) % (64'd1 << W);
      if (NC && !canon[in_declet]) m_ncan = 1;
      if (in_last) m_done = 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [W-1:0] eb;
    eb = m_done ? (m_ovf ? {W{1'b1}} : W'(m_acc)) : '0;
    chk("in_ready", in_ready, !m_done);
    chk("out_valid", out_valid, m_done);
    chk("out_bin", out_bin, eb);
    chk("out_ovf", out_ovf, m_done & m_ovf);
    chk("out_ncan", out_ncan, m_done & m_ncan);
  end

  task automatic send(logic [9:0] d, logic last);
    int n;
    in_valid = 1'b1;
    in_declet = d;
    in_last = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("send_timeout", n < 50, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic res(string nm, logic [W-1:0] b, logic o, logic c);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_bin"}, out_bin, b);
    chk({nm, "_ovf"}, out_ovf, o);
    chk({nm, "_ncan"}, out_ncan, c);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    for (int v = 0; v < 1000; v++) begin
      dec_tab[enc(v)] = v;
      canon[enc(v)] = 1'b1;
    end
    for (int c = 0; c < 1024; c++)
      if (!canon[c]) dec_tab[c] = dec_tab[c & 10'h0FF];

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_bin", out_bin, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(10'h0A3, 1);
    res("single", 123, 0, 0);

    send(10'h0A3, 0);
    send(10'h256, 1);
    res("two", 123456, 0, 0);

    send(10'h0FF, 0);
    send(10'h0FF, 0);
    send(10'h0FF, 1);
    res("max", 30'h3B9AC9FF, 0, 0);

    for (int i = 0; i < 3; i++) send(10'h0A3, 0);
    send(10'h0A3, 1);
    res("ovf", 30'h3FFFFFFF, 1, 0);

    send(10'h3FF, 1);
    res("ncan", 999, 0, NC);

    send(10'h3FF, 0);
    send(10'h0A3, 1);
    res("ncan2", 999123, 0, NC);

    // backpressure with a declet already waiting
    send(10'h0A3, 1);
    in_valid = 1'b1;
    in_declet = 10'h256;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_bin", out_bin, 123);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    res("bp_next", 456, 0, 0);

    // reset mid-ACCUM discards the partial value
    send(10'h0A3, 0);
    send(10'h256, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc_valid", out_valid, 0);
    chk("rstacc_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(10'h0A3, 1);
    res("after_rst", 123, 0, 0);

    // reset in DONE drops the pending result
    send(10'h0FF, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstdone_valid", out_valid, 0);
    chk("rstdone_ready", in_ready, 1);
    chk("rstdone_bin", out_bin, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // every declet code as a one-declet number
    for (int c = 0; c < 1024; c++) begin
      send(10'(c), 1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end

    // random multi-declet numbers with random consumer delay
    for (int k = 0; k < 60; k++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++)
        send(10'($urandom_range(0, 1023)), j == len - 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpd_stream_to_bin.md
DPD_STREAM_TO_BIN -- requirements
Module: dpd_stream_to_bin

Interface
REQ-001 The block SHALL have parameter MAX_DECLETS, default 3: the maximum number of declets per number. Output width is W = 10*MAX_DECLETS, which is 30 at the default.
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have in_valid, input, 1 bit: in_declet and in_last are valid.
REQ-005 The block SHALL have in_ready, output, 1 bit: the block accepts a declet this cycle.
REQ-006 The block SHALL have in_declet, input, 10 bits: one densely-packed-decimal declet, most significant declet first.
REQ-007 The block SHALL have in_last, input, 1 bit: this declet ends the number.
REQ-008 The block SHALL have out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have out_bin, output, W bits: the binary value of the decimal number.
REQ-011 The block SHALL have out_ovf, output, 1 bit: more than MAX_DECLETS declets were received.
REQ-012 The block SHALL have out_ncan, output, 1 bit: at least one non-canonical declet was received.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-014 The block SHALL drive in_ready = 1 in IDLE and ACCUM and in_ready = 0 in DONE.
REQ-015 A declet is accepted on a rising edge with in_valid & in_ready.
REQ-016 Each accepted declet SHALL be unpacked combinationally to BCD digits d2, d1, d0 per IEEE 754-2008 DPD, giving v = 100*d2 + 10*d1 + d0 in the range 0..999.
REQ-017 On acceptance, the accumulator SHALL update acc <= acc*1000 + v, where acc is W bits and is zero on entry from IDLE.
REQ-018 A declet count SHALL increment per accepted declet and saturate at MAX_DECLETS+1.
REQ-019 Accepting declet number MAX_DECLETS+1 or later SHALL set sticky ovf, and the accumulator SHALL no longer update.
REQ-020 Transitions SHALL be:
- IDLE to ACCUM on acceptance with in_last = 0.
- IDLE or ACCUM to DONE on acceptance with in_last = 1.
- ACCUM holds otherwise; there is no timeout.
REQ-021 out_valid SHALL be 1 exactly while in DONE, so the latency from accepting the last declet to out_valid is 1 cycle.
REQ-022 In DONE, out_bin = ovf ? all ones : acc, out_ovf = ovf and out_ncan = ncan, all held stable until the handshake.
REQ-023 In DONE, out_valid & out_ready SHALL return the FSM to IDLE and clear acc, count, ovf and ncan.
REQ-024 in_valid asserted in the same cycle as the DONE handshake SHALL NOT be accepted, because in_ready = 0; the declet is accepted the following cycle.
REQ-025 When the FSM is not in DONE, out_bin, out_ovf and out_ncan SHALL be 0.

Reset
REQ-026 rst_n = 0 SHALL immediately force the following, regardless of clk:
- FSM to IDLE.
- acc, count, ovf and ncan to 0.
- out_valid = 0, out_bin = 0, out_ovf = 0, out_ncan = 0, in_ready = 1.
REQ-027 Reset during ACCUM or DONE SHALL discard the partial or unconsumed result with no output handshake.

Configuration
REQ-028 With DPD_NONCANON_CHECK_EN defined, an accepted declet SHALL set sticky ncan when all of the following hold:
- in_declet[3:1] = 111
- in_declet[6:5] = 11
- in_declet[9:8] != 00
These are the 24 redundant codes; the declet is still decoded to its value per REQ-016.
REQ-029 Without DPD_NONCANON_CHECK_EN, the out_ncan port SHALL remain present and be tied to 0, and no check logic SHALL be synthesised.

Verification
REQ-030 Single declet 0x0A3 with in_last = 1 -> next cycle out_valid = 1, out_bin = 123, out_ovf = 0.
REQ-031 Declets 0x0A3 then 0x256 (last), back-to-back -> out_bin = 123456 one cycle after the second acceptance.
REQ-032 Declets 0x0FF, 0x0FF, 0x0FF (last) -> out_bin = 999999999 (0x3B9AC9FF), out_ovf = 0.
REQ-033 Four declets 0x0A3 (last on the fourth) -> out_ovf = 1, out_bin = 0x3FFFFFFF.
REQ-034 Backpressure case:
- Stimulus: result pending with out_ready = 0 for 5 cycles while in_valid = 1.
- Response: out_bin stable and in_ready = 0 for those cycles; after the out_ready pulse, the next declet is accepted one cycle later.
REQ-035 Declet 0x3FF (last), with the macro defined -> out_bin = 999, out_ncan = 1; with the macro undefined -> out_ncan = 0.
REQ-036 Reset pulse asserted mid-ACCUM -> out_valid = 0 and in_ready = 1 immediately; a subsequent 0x0A3 (last) yields out_bin = 123.
